pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB register set.
//  - Detects load-use hazards, taken-branch redirects and data-memory wait states.
//  - Drives the per-stage stall_*/flush_* controls and the PC write enable.
//  - Keeps saturating perf counters and a sticky memory-timeout error flag.

---
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Resolves data-memory waits, taken redirects and load-use hazards in
// fixed priority. It drives per-stage hold/bubble controls and the PC enable.
// It also keeps saturating perf counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             pc_write_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout_err
);

  localparam logic S_RUN      = 1'b0;
  localparam logic S_REDIRECT = 1'b1;

  // bubble_cnt must hold REDIRECT_BUBBLES-1.
  // wait_cnt must hold MEM_TIMEOUT-1 and saturates there.
  localparam int BW = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [BW-1:0] BUBBLE_INIT = BW'(REDIRECT_BUBBLES - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(MEM_TIMEOUT - 1);

  logic          state;
  logic [BW-1:0] bubble_cnt;
  logic [WW-1:0] wait_cnt;
  logic          mem_busy;
  logic          load_use;
  logic          redirect_take;

  assign mem_busy = mem_req & ~dmem_ready;
  assign load_use = ex_mem_read & (ex_rd_addr != 5'd0) &
                    ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                     (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
  // A redirect seen while memory is busy is held until the wait ends.
  assign redirect_take = ex_redirect & ~mem_busy;

  // Prioritised control decode.
  // Everything reads deasserted (PC frozen) while reset is held.
  always_comb begin
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    pc_write_en  = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        // Freeze everything upstream of MEM and drain a bubble into WB.
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
      end else if (ex_redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        pc_write_en = 1'b1;
      end else if (state == S_REDIRECT) begin
        flush_if_id = 1'b1;
        pc_write_en = 1'b1;
      end else if (load_use) begin
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else begin
        pc_write_en = 1'b1;
      end
    end
  end

  // Redirect sequencing: a new redirect (re)loads the bubble count.
  // The last REDIRECT cycle is the one that observes bubble_cnt==1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      bubble_cnt <= '0;
    end else if (!mem_busy) begin
      if (ex_redirect) begin
        if (REDIRECT_BUBBLES > 1) begin
          state      <= S_REDIRECT;
          bubble_cnt <= BUBBLE_INIT;
        end else begin
          state      <= S_RUN;
          bubble_cnt <= '0;
        end
      end else if (state == S_REDIRECT) begin
        if (bubble_cnt <= BW'(1)) begin
          state      <= S_RUN;
          bubble_cnt <= '0;
        end else begin
          bubble_cnt <= bubble_cnt - BW'(1);
        end
      end
    end
  end

  // Consecutive dmem-wait tracking and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else if (mem_busy) begin
      if (wait_cnt == WAIT_LAST) mem_timeout_err <= 1'b1;
      else                       wait_cnt        <= wait_cnt + WW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating perf counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_take && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Each step queues its expected controls, which are popped and checked mid-cycle.
// Counters and the timeout flag are checked just after clock edges.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, dmem_ready;
  logic stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic pc_write_en, mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  typedef struct packed {
    logic [3:0] st;   // {if_id, id_ex, ex_mem, mem_wb}
    logic [3:0] fl;
    logic       pcw;
  } ctrl_t;

  ctrl_t exp_q[$];
  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(3), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .pc_write_en(pc_write_en), .stall_cycles(stall_cycles),
    .flush_events(flush_events), .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd_addr = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic load(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic [4:0] rd, input logic mr);
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd_addr = rd; ex_mem_read = mr;
  endtask

  // Inputs are already driven; queue expectation, check mid-cycle, then clock.
  task automatic step(input string tag, input logic [3:0] st, input logic [3:0] fl,
                      input logic pcw);
    ctrl_t e, o;
    e.st = st; e.fl = fl; e.pcw = pcw;
    exp_q.push_back(e);
    #2;
    o.st  = {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb};
    o.fl  = {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
    o.pcw = pc_write_en;
    e = exp_q.pop_front();
    chk(tag, 32'(o), 32'(e));
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    step("reset_ctrl", 4'b0000, 4'b0000, 1'b0);
    chk("reset_sc", 32'(stall_cycles), 0);
    chk("reset_fe", 32'(flush_events), 0);
    chk("reset_err", 32'(mem_timeout_err), 0);
    rst_n = 1'b1;

    step("idle", 4'b0000, 4'b0000, 1'b1);
    chk("idle_sc", 32'(stall_cycles), 0);

    // load-use via rs1
    load(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1);
    step("lu_rs1", 4'b1000, 4'b0100, 1'b0);
    chk("lu_sc", 32'(stall_cycles), 1);
    // rd = x0 never hazards
    load(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);
    step("lu_x0", 4'b0000, 4'b0000, 1'b1);
    // matching rs1 that is not read
    load(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
    step("lu_unused", 4'b0000, 4'b0000, 1'b1);
    // load-use via rs2
    load(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1);
    step("lu_rs2", 4'b1000, 4'b0100, 1'b0);
    chk("lu2_sc", 32'(stall_cycles), 2);
    // matching register but EX is not a load
    load(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
    step("no_load", 4'b0000, 4'b0000, 1'b1);

    // redirect pulse: 3 IF/ID flushes, 1 ID/EX flush; load-use ignored mid-redirect
    idle_inputs();
    ex_redirect = 1'b1;
    step("redir_0", 4'b0000, 4'b1100, 1'b1);
    ex_redirect = 1'b0;
    load(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1);
    step("redir_1_lu", 4'b0000, 4'b1000, 1'b1);
    idle_inputs();
    step("redir_2", 4'b0000, 4'b1000, 1'b1);
    step("redir_done", 4'b0000, 4'b0000, 1'b1);
    chk("redir_fe", 32'(flush_events), 1);
    chk("redir_sc", 32'(stall_cycles), 2);

    // redirect restart inside REDIRECT
    ex_redirect = 1'b1;
    step("rst_r0", 4'b0000, 4'b1100, 1'b1);
    step("rst_r1", 4'b0000, 4'b1100, 1'b1);
    ex_redirect = 1'b0;
    step("rst_r2", 4'b0000, 4'b1000, 1'b1);
    step("rst_r3", 4'b0000, 4'b1000, 1'b1);
    step("rst_done", 4'b0000, 4'b0000, 1'b1);
    chk("restart_fe", 32'(flush_events), 3);

    // memory wait holds a pending redirect for 4 cycles
    ex_redirect = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("busy_redir", 4'b1110, 4'b0001, 1'b0);
    chk("busy_fe", 32'(flush_events), 3);
    chk("busy_sc", 32'(stall_cycles), 6);
    dmem_ready = 1'b1;
    step("held_redir", 4'b0000, 4'b1100, 1'b1);
    chk("held_fe", 32'(flush_events), 4);
    idle_inputs();
    step("held_r1", 4'b0000, 4'b1000, 1'b1);
    step("held_r2", 4'b0000, 4'b1000, 1'b1);
    chk("busy_err", 32'(mem_timeout_err), 0);

    // timeout after 8 consecutive busy cycles; stall counter saturates at 15
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 7; i++) step("to_busy", 4'b1110, 4'b0001, 1'b0);
    chk("to_err_7", 32'(mem_timeout_err), 0);
    step("to_busy8", 4'b1110, 4'b0001, 1'b0);
    chk("to_err_8", 32'(mem_timeout_err), 1);
    chk("to_sc", 32'(stall_cycles), 14);
    step("to_busy9", 4'b1110, 4'b0001, 1'b0);
    chk("sat_sc15", 32'(stall_cycles), 15);
    step("to_busy10", 4'b1110, 4'b0001, 1'b0);
    chk("sat_sc_hold", 32'(stall_cycles), 15);
    dmem_ready = 1'b1;
    step("to_ready", 4'b0000, 4'b0000, 1'b1);
    chk("to_err_sticky", 32'(mem_timeout_err), 1);

    // async reset in the middle of REDIRECT
    idle_inputs();
    ex_redirect = 1'b1;
    step("rr_0", 4'b0000, 4'b1100, 1'b1);
    ex_redirect = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rr_pcw", 32'(pc_write_en), 0);
    chk("rr_flush", 32'({flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}), 0);
    chk("rr_sc", 32'(stall_cycles), 0);
    chk("rr_fe", 32'(flush_events), 0);
    chk("rr_err", 32'(mem_timeout_err), 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step("rr_after", 4'b0000, 4'b0000, 1'b1);
    chk("rr_after_sc", 32'(stall_cycles), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
